// File: rtl/lbp_hist_if.sv
// Stream and dump-handshake signals between the LBP engine, lbp_hist and the classifier side.
// The slave modport is the histogram block's view; the master modport drives it.
interface lbp_hist_if #(
    parameter int CNT_W = 14
);
    logic             lbp_valid;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic [CNT_W-1:0] sample_total;
    logic             hist_done;

    modport master (
        output lbp_valid, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, sample_total, hist_done
    );

    modport slave (
        input  lbp_valid, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, sample_total, hist_done
    );
endinterface

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a 256-bin histogram of LBP codes for one frame, then streams the bins out.
// Optional macro LBP_HIST_SKIPZERO_EN: the dump skips bins whose count is zero.
module lbp_hist #(
    parameter int CNT_W = 14,
    parameter int BINS  = 256
) (
    input logic       clk,
    input logic       reset,
    lbp_hist_if.slave bus
);
    localparam int               PTR_W   = $clog2(BINS) + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(BINS);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bins_q [BINS];
    logic [CNT_W-1:0] bins_d [BINS];
    logic [CNT_W-1:0] total_q, total_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             valid_dly_q, valid_dly_d;
    logic             hist_valid_q, hist_valid_d;
    logic [7:0]       hist_bin_q, hist_bin_d;
    logic [CNT_W-1:0] hist_count_q, hist_count_d;
    logic             hist_done_q, hist_done_d;

    logic             accept_s;
    logic             skip_s;
    logic [CNT_W-1:0] ptr_cnt_s;

    assign ptr_cnt_s = bins_q[ptr_q[PTR_W-2:0]];

`ifdef LBP_HIST_SKIPZERO_EN
    assign skip_s = (ptr_cnt_s == {CNT_W{1'b0}});
`else
    assign skip_s = 1'b0;
`endif

    // Next-state, dump sequencing and saturating accumulation.
    always_comb begin
        state_d      = state_q;
        bins_d       = bins_q;
        total_d      = total_q;
        ptr_d        = ptr_q;
        valid_dly_d  = bus.lbp_valid;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        hist_count_d = hist_count_q;
        hist_done_d  = hist_done_q;
        accept_s     = 1'b0;

        case (state_q)
            ACCUM: begin
                // Rising edge of lbp_valid only: the engine parks valid high after its last pixel.
                accept_s = bus.lbp_valid && !valid_dly_q;
                if (bus.finish) begin
                    state_d = DUMP;
                    ptr_d   = {PTR_W{1'b0}};
                end else begin
                    state_d = ACCUM;
                end
            end
            DUMP: begin
                if (hist_valid_q && !bus.hist_ready) begin
                    hist_valid_d = 1'b1;
                end else if (ptr_q == PTR_END) begin
                    state_d      = DONE;
                    hist_valid_d = 1'b0;
                    hist_done_d  = 1'b1;
                end else begin
                    hist_valid_d = !skip_s;
                    hist_bin_d   = ptr_q[7:0];
                    hist_count_d = ptr_cnt_s;
                    ptr_d        = ptr_q + PTR_ONE;
                end
            end
            DONE: begin
                hist_valid_d = 1'b0;
                hist_done_d  = 1'b1;
            end
            default: begin
                state_d      = ACCUM;
                hist_valid_d = 1'b0;
                hist_done_d  = 1'b0;
            end
        endcase

        if (accept_s) begin
            if (bins_q[bus.lbp_data] != CNT_MAX) begin
                bins_d[bus.lbp_data] = bins_q[bus.lbp_data] + CNT_ONE;
            end else begin
                bins_d[bus.lbp_data] = CNT_MAX;
            end
            if (total_q != CNT_MAX) begin
                total_d = total_q + CNT_ONE;
            end else begin
                total_d = CNT_MAX;
            end
        end else begin
            total_d = total_q;
        end
    end

    // State, bin storage and registered dump outputs; reset clears every bin at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            total_q      <= {CNT_W{1'b0}};
            ptr_q        <= {PTR_W{1'b0}};
            valid_dly_q  <= 1'b0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= 8'd0;
            hist_count_q <= {CNT_W{1'b0}};
            hist_done_q  <= 1'b0;
            for (int i = 0; i < BINS; i++) begin
                bins_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            ptr_q        <= ptr_d;
            valid_dly_q  <= valid_dly_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_count_q <= hist_count_d;
            hist_done_q  <= hist_done_d;
            bins_q       <= bins_d;
        end
    end

    assign bus.hist_valid   = hist_valid_q;
    assign bus.hist_bin     = hist_bin_q;
    assign bus.hist_count   = hist_count_q;
    assign bus.sample_total = total_q;
    assign bus.hist_done    = hist_done_q;
endmodule
